// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath width and the 4-bit operation codes.
// Decode and branch logic import the same definitions.
package alu_pkg;

   localparam int WIDTH_DATA = 32;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_NOP   = 4'h0;
   localparam alu_op_t ALU_ADD   = 4'h1;
   localparam alu_op_t ALU_SUB   = 4'h2;
   localparam alu_op_t ALU_SLL   = 4'h3;
   localparam alu_op_t ALU_SLT   = 4'h4;
   localparam alu_op_t ALU_SLTU  = 4'h5;
   localparam alu_op_t ALU_SRL   = 4'h6;
   localparam alu_op_t ALU_SRA   = 4'h7;
   localparam alu_op_t ALU_XOR   = 4'h8;
   localparam alu_op_t ALU_OR    = 4'h9;
   localparam alu_op_t ALU_AND   = 4'hA;
   localparam alu_op_t ALU_LUI   = 4'hB;
   localparam alu_op_t ALU_AUIPC = 4'hC;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: left logical, right logical, or right arithmetic.
// A shift amount of zero passes the operand through unchanged.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH_DATA = alu_pkg::WIDTH_DATA,
   parameter int SH_W       = $clog2(WIDTH_DATA)
) (
   input  logic [WIDTH_DATA-1:0] data_in,
   input  logic [SH_W-1:0]       shamt,
   input  logic                  left,
   input  logic                  arith,
   output logic [WIDTH_DATA-1:0] data_out
);

   always_comb begin
      data_out = '0;
      if (left) begin
         data_out = data_in << shamt;
      end else if (arith) begin
         data_out = $signed(data_in) >>> shamt;
      end else begin
         data_out = data_in >> shamt;
      end
   end

endmodule

// File: rtl/alu_core.sv
// RV32I execute-stage ALU with one-cycle registered result and zero flag.
// Optional feature: define ALU_OVF_EN to add the registered signed `overflow` output.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH_DATA = alu_pkg::WIDTH_DATA
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [WIDTH_DATA-1:0] data1_in,
   input  logic [WIDTH_DATA-1:0] data2_in,
   input  logic [3:0]            select_alu,
   output logic                  out_valid,
   output logic [WIDTH_DATA-1:0] data_out,
   output logic                  zero
`ifdef ALU_OVF_EN
   ,
   output logic                  overflow
`endif
);

   localparam int SH_W = $clog2(WIDTH_DATA);

   // Handshake: in_valid qualifies operands and select for one cycle; out_valid
   // rises the following cycle with that result. There is no ready/backpressure.

   logic                  is_sub;
   logic [WIDTH_DATA-1:0] b_eff;
   logic [WIDTH_DATA-1:0] sum;
   logic                  lt_s;
   logic                  lt_u;
   logic [WIDTH_DATA-1:0] shift_res;
   logic [WIDTH_DATA-1:0] result;

   // SUB reuses the adder as A + ~B + 1
   assign is_sub = (select_alu == ALU_SUB);
   assign b_eff  = is_sub ? ~data2_in : data2_in;
   assign sum    = data1_in + b_eff + {{(WIDTH_DATA-1){1'b0}}, is_sub};
   assign lt_s   = $signed(data1_in) < $signed(data2_in);
   assign lt_u   = data1_in < data2_in;

   alu_shifter #(
      .WIDTH_DATA (WIDTH_DATA),
      .SH_W       (SH_W)
   ) u_shifter (
      .data_in  (data1_in),
      .shamt    (data2_in[SH_W-1:0]),
      .left     (select_alu == ALU_SLL),
      .arith    (select_alu == ALU_SRA),
      .data_out (shift_res)
   );

   always_comb begin
      result = '0;
      case (select_alu)
         ALU_ADD, ALU_SUB, ALU_AUIPC: result = sum;
         ALU_SLL, ALU_SRL, ALU_SRA:   result = shift_res;
         ALU_SLT:                     result = {{(WIDTH_DATA-1){1'b0}}, lt_s};
         ALU_SLTU:                    result = {{(WIDTH_DATA-1){1'b0}}, lt_u};
         ALU_XOR:                     result = data1_in ^ data2_in;
         ALU_OR:                      result = data1_in | data2_in;
         ALU_AND:                     result = data1_in & data2_in;
         ALU_LUI:                     result = data2_in;
         default:                     result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         zero      <= 1'b1;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            data_out <= result;
            zero     <= (result == '0);
         end
      end
   end

`ifdef ALU_OVF_EN
   logic ovf_next;

   // b_eff already carries the inverted B for SUB, so one same-sign rule covers both
   always_comb begin
      ovf_next = 1'b0;
      if (select_alu == ALU_ADD || select_alu == ALU_SUB || select_alu == ALU_AUIPC) begin
         ovf_next = (data1_in[WIDTH_DATA-1] == b_eff[WIDTH_DATA-1]) &&
                    (sum[WIDTH_DATA-1] != data1_in[WIDTH_DATA-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (in_valid) begin
         overflow <= ovf_next;
      end
   end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (WIDTH_DATA=32), table-driven vectors plus
// reset/hold sequences; builds with or without ALU_OVF_EN.
module tb_alu_core;

   localparam int W = 32;

   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_SLL   = 4'h3;
   localparam logic [3:0] OP_SLT   = 4'h4;
   localparam logic [3:0] OP_SLTU  = 4'h5;
   localparam logic [3:0] OP_SRL   = 4'h6;
   localparam logic [3:0] OP_SRA   = 4'h7;
   localparam logic [3:0] OP_XOR   = 4'h8;
   localparam logic [3:0] OP_OR    = 4'h9;
   localparam logic [3:0] OP_AND   = 4'hA;
   localparam logic [3:0] OP_LUI   = 4'hB;
   localparam logic [3:0] OP_AUIPC = 4'hC;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      logic         exp_zero;
      logic         exp_ovf;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] data1_in;
   logic [W-1:0] data2_in;
   logic [3:0]   select_alu;
   logic         out_valid;
   logic [W-1:0] data_out;
   logic         zero;
`ifdef ALU_OVF_EN
   logic         overflow;
`endif

   logic [W-1:0] exp_q[$];
   logic         exp_zero_q[$];
   logic         exp_ovf_q[$];
   vec_t         vecs[$];
   int           n_cmp;
   int           n_fail;
   int           n_sent;
   int           n_rcvd;

   alu_core #(.WIDTH_DATA(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .data1_in   (data1_in),
      .data2_in   (data2_in),
      .select_alu (select_alu),
      .out_valid  (out_valid),
      .data_out   (data_out),
      .zero       (zero)
`ifdef ALU_OVF_EN
      ,
      .overflow   (overflow)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // driver: applies one op at the falling edge; push=1 records its expected result
   task automatic drive(input vec_t v, input bit push);
      @(negedge clk);
      in_valid   = 1'b1;
      select_alu = v.op;
      data1_in   = v.a;
      data2_in   = v.b;
      if (push) begin
         exp_q.push_back(v.exp);
         exp_zero_q.push_back(v.exp_zero);
         exp_ovf_q.push_back(v.exp_ovf);
         n_sent++;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid   = 1'b0;
      select_alu = 4'($urandom_range(0, 15));
      data1_in   = $urandom;
      data2_in   = $urandom;
   endtask

   // scoreboard
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         n_rcvd++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: actual %h required none", data_out);
         end else begin
            check("data_out", data_out, exp_q.pop_front());
            check("zero", W'(zero), W'(exp_zero_q.pop_front()));
`ifdef ALU_OVF_EN
            check("overflow", W'(overflow), W'(exp_ovf_q[0]));
`endif
            void'(exp_ovf_q.pop_front());
         end
      end
   end

   task automatic drain(input string name);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      check(name, W'(exp_q.size()), '0);
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; n_sent = 0; n_rcvd = 0;
      rst = 1'b1; in_valid = 1'b0; select_alu = '0; data1_in = '0; data2_in = '0;

      vecs.push_back('{OP_ADD,   32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0});
      vecs.push_back('{OP_SUB,   32'h03800155, 32'h00055400, 32'h037AAD55, 1'b0, 1'b0});
      vecs.push_back('{OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{OP_SLL,   32'h03800155, 32'h00000004, 32'h38001550, 1'b0, 1'b0});
      vecs.push_back('{OP_SRL,   32'h03800155, 32'h00000004, 32'h00380015, 1'b0, 1'b0});
      vecs.push_back('{OP_SRA,   32'h83800155, 32'h00000004, 32'hF8380015, 1'b0, 1'b0});
      vecs.push_back('{OP_SLL,   32'h03800155, 32'hFFFFFFE0, 32'h03800155, 1'b0, 1'b0});
      vecs.push_back('{OP_SRA,   32'h83800155, 32'hFFFFFFE0, 32'h83800155, 1'b0, 1'b0});
      vecs.push_back('{OP_SRL,   32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0});
      vecs.push_back('{OP_SLL,   32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0});
      vecs.push_back('{OP_SRA,   32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0});
      vecs.push_back('{OP_SLT,   32'h00000004, 32'h03800155, 32'h00000001, 1'b0, 1'b0});
      vecs.push_back('{OP_SLTU,  32'h03800155, 32'h00000004, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{OP_SLT,   32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
      vecs.push_back('{OP_SLTU,  32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{OP_SLT,   32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{OP_SLTU,  32'h7FFFFFFF, 32'h80000000, 32'h00000001, 1'b0, 1'b0});
      vecs.push_back('{OP_XOR,   32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0});
      vecs.push_back('{OP_OR,    32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0});
      vecs.push_back('{OP_AND,   32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{OP_LUI,   32'h12345678, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 1'b0});
      vecs.push_back('{OP_AUIPC, 32'h00000040, 32'h00000040, 32'h00000080, 1'b0, 1'b0});
      vecs.push_back('{4'hF,     32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{4'h0,     32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{4'hD,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
      vecs.push_back('{OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1});
      vecs.push_back('{OP_ADD,   32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0});
      vecs.push_back('{OP_AUIPC, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
      vecs.push_back('{OP_SUB,   32'h00000001, 32'h80000000, 32'h80000001, 1'b0, 1'b1});

      // reset state
      repeat (3) @(negedge clk);
      check("reset_data_out", data_out, '0);
      check("reset_zero", W'(zero), W'(1));
      check("reset_out_valid", W'(out_valid), '0);
`ifdef ALU_OVF_EN
      check("reset_overflow", W'(overflow), '0);
`endif
      rst = 1'b0;

      // back-to-back table stream
      foreach (vecs[i]) drive(vecs[i], 1'b1);
      idle();
      drain("stream_drain");
      check("stream_count", W'(n_rcvd), W'(n_sent));

      // hold: a nonzero, overflowing result must persist while in_valid=0
      drive('{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1}, 1'b1);
      idle();
      for (int k = 0; k < 3; k++) begin
         idle();
         check("hold_out_valid", W'(out_valid), '0);
         check("hold_data_out", data_out, 32'h80000000);
         check("hold_zero", W'(zero), '0);
`ifdef ALU_OVF_EN
         check("hold_overflow", W'(overflow), W'(1));
`endif
      end
      drain("hold_drain");

      // reset wins over in_valid
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1; select_alu = OP_ADD; data1_in = 32'h1; data2_in = 32'h1;
      @(negedge clk);
      check("rst_vs_valid_data_out", data_out, '0);
      check("rst_vs_valid_zero", W'(zero), W'(1));
      check("rst_vs_valid_out_valid", W'(out_valid), '0);
`ifdef ALU_OVF_EN
      check("rst_vs_valid_overflow", W'(overflow), '0);
`endif
      rst = 1'b0;
      in_valid = 1'b0;

      // recovery after reset
      drive('{OP_XOR, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1'b0, 1'b0}, 1'b1);
      idle();
      drain("recover_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
